// File: rtl/pid_pos_sequencer.sv
// Sample-rate PID position sequencer: captures gains/positions each sample period,
// runs P, I, D through one registered multiplier and publishes a clamped duty + direction.
module pid_pos_sequencer #(
  parameter int SAMPLE_DIV = 100000,
  parameter int FRAC_BITS  = 8,
  parameter int INT_LIM    = 1000000,
  parameter int DUTY_MAX   = 1000
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        enable,
  input  logic [15:0] kp_init,
  input  logic [15:0] ki_init,
  input  logic [15:0] kd_init,
  input  logic [31:0] desired_pos,
  input  logic [31:0] actual_pos,
  output logic [15:0] duty,
  output logic        dir,
  output logic        update,
  output logic        busy,
  output logic        sat
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [33:0] INT_HI = 34'(INT_LIM);
  localparam logic signed [33:0] INT_LO = -INT_HI;
  localparam logic [51:0] DUTY_LIM = 52'(DUTY_MAX);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, ERR, MUL_P, MUL_I, MUL_D, SUM, OUT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [15:0]        kp_q, ki_q, kd_q;
  logic [31:0]        des_q, act_q;
  logic signed [31:0] e_q, e_prev, integ;
  logic signed [32:0] deriv;
  logic               first;
  logic signed [49:0] prod;
  logic signed [51:0] acc;

  logic signed [32:0] e_wide;
  logic signed [31:0] e_sat;
  logic signed [33:0] integ_sum;
  logic signed [31:0] integ_clamp;
  logic signed [32:0] deriv_next;
  logic signed [49:0] mul_a, mul_b, prod_next;
  logic signed [51:0] acc_sum, u;
  logic [51:0]        mag;
  logic [15:0]        duty_next;
  logic               sat_next;

  assign tick   = enable && (cnt == CNT_LAST);
  assign update = (state == OUT);
  assign busy   = (state != IDLE);

  // Sample counter is parked at zero while disabled so the first tick lands SAMPLE_DIV cycles after enable.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn)
      cnt <= '0;
    else if (!enable || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = CAPTURE;
      CAPTURE: state_next = ERR;
      ERR:     state_next = MUL_P;
      MUL_P:   state_next = MUL_I;
      MUL_I:   state_next = MUL_D;
      MUL_D:   state_next = SUM;
      SUM:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!enable)
      state_next = IDLE;
  end

  // Error, integrator and derivative terms, all saturated/clamped before they reach the multiplier.
  always_comb begin
    e_wide = {des_q[31], des_q} - {act_q[31], act_q};
    if (e_wide[32] != e_wide[31])
      e_sat = e_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      e_sat = e_wide[31:0];

    integ_sum = {{2{integ[31]}}, integ} + {{2{e_sat[31]}}, e_sat};
    if (integ_sum > INT_HI)
      integ_clamp = INT_HI[31:0];
    else if (integ_sum < INT_LO)
      integ_clamp = INT_LO[31:0];
    else
      integ_clamp = integ_sum[31:0];

    if (first)
      deriv_next = '0;
    else
      deriv_next = {e_sat[31], e_sat} - {e_prev[31], e_prev};
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_P: begin
        mul_a = {34'b0, kp_q};
        mul_b = {{18{e_q[31]}}, e_q};
      end
      MUL_I: begin
        mul_a = {34'b0, ki_q};
        mul_b = {{18{integ[31]}}, integ};
      end
      MUL_D: begin
        mul_a = {34'b0, kd_q};
        mul_b = {{17{deriv[32]}}, deriv};
      end
      default: ;
    endcase
  end

  assign prod_next = mul_a * mul_b;

  // The last product is folded in combinationally during SUM so the outputs are visible in OUT.
  always_comb begin
    acc_sum = acc + {{2{prod[49]}}, prod};
    u       = acc_sum >>> FRAC_BITS;
    mag     = u[51] ? 52'(-u) : 52'(u);
    sat_next = (mag > DUTY_LIM);
    duty_next = sat_next ? 16'(DUTY_MAX) : mag[15:0];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      kp_q   <= '0;
      ki_q   <= '0;
      kd_q   <= '0;
      des_q  <= '0;
      act_q  <= '0;
      e_q    <= '0;
      e_prev <= '0;
      integ  <= '0;
      deriv  <= '0;
      first  <= 1'b1;
      prod   <= '0;
      acc    <= '0;
      duty   <= '0;
      dir    <= 1'b0;
      sat    <= 1'b0;
    end else if (!enable) begin
      duty   <= '0;
      dir    <= 1'b0;
      sat    <= 1'b0;
      integ  <= '0;
      e_prev <= '0;
      first  <= 1'b1;
    end else begin
      case (state)
        CAPTURE: begin
          kp_q  <= kp_init;
          ki_q  <= ki_init;
          kd_q  <= kd_init;
          des_q <= desired_pos;
          act_q <= actual_pos;
          acc   <= '0;
        end
        ERR: begin
          e_q    <= e_sat;
          e_prev <= e_sat;
          integ  <= integ_clamp;
          deriv  <= deriv_next;
          first  <= 1'b0;
        end
        MUL_P: prod <= prod_next;
        MUL_I: begin
          prod <= prod_next;
          acc  <= acc_sum;
        end
        MUL_D: begin
          prod <= prod_next;
          acc  <= acc_sum;
        end
        SUM: begin
          acc  <= acc_sum;
          duty <= duty_next;
          dir  <= u[51];
          sat  <= sat_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_pos_sequencer.sv
// Directed bench for pid_pos_sequencer: table of per-sample vectors plus hand sequences
// for reset latency, mid-sequence abort and capture stability.
module tb_pid_pos_sequencer;

  localparam int SAMPLE_DIV = 10;
  localparam int FRAC_BITS  = 8;
  localparam int INT_LIM    = 250;
  localparam int DUTY_MAX   = 1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] kp, ki, kd;
  logic [31:0] desired, actual;
  logic [15:0] duty;
  logic        dir, update, busy, sat;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pid_pos_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .FRAC_BITS (FRAC_BITS),
    .INT_LIM   (INT_LIM),
    .DUTY_MAX  (DUTY_MAX)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rstn),
    .enable         (enable),
    .kp_init        (kp),
    .ki_init        (ki),
    .kd_init        (kd),
    .desired_pos    (desired),
    .actual_pos     (actual),
    .duty           (duty),
    .dir            (dir),
    .update         (update),
    .busy           (busy),
    .sat            (sat)
  );

  typedef struct {
    logic        restart;
    logic [15:0] kp, ki, kd;
    logic [31:0] des, act;
    logic [15:0] exp_duty;
    logic        exp_dir;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic waitUpdate(output int edges);
    edges = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (update) return;
    end
    checks++;
    $display("[TB] FAIL update timeout: got none in %0d cycles, expected a pulse", edges);
    edges = -1;
  endtask

  task automatic waitBusyRise(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    $display("[TB] FAIL busy timeout: got busy=0, expected 1");
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.restart) begin
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    kp      = v.kp;
    ki      = v.ki;
    kd      = v.kd;
    desired = v.des;
    actual  = v.act;
    enable  = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   edges, bad, busy_cnt, upd_cnt;
    logic ok;

    //              rst   kp        ki        kd        des            act            duty    dir   sat
    vecs[0]  = '{1'b1, 16'h0100, 16'h0000, 16'h0000, 32'd500,       32'd200,       16'd300,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 32'd500,       32'd750,       16'd500,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 32'd5000,      32'd0,         16'd1000, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, -32'sd5000,    32'd0,         16'd1000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 16'h0080, 16'h0000, 16'h0000, 32'd0,         32'd3,         16'd2,    1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0080, 16'h0000, 16'h0000, 32'd3,         32'd0,         16'd1,    1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0001, 16'h0000, 16'h0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'd1000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'h03E8, 16'h0000, 16'h0000, 32'd256,       32'd0,         16'd1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h03E8, 16'h0000, 16'h0000, 32'd257,       32'd0,         16'd1000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 16'h0000, 16'h0100, 16'h0000, 32'd100,       32'd0,         16'd100,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0100, 16'h0000, 32'd100,       32'd0,         16'd200,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 16'h0100, 16'h0000, 32'd100,       32'd0,         16'd250,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 16'h0100, 16'h0000, 32'd100,       32'd0,         16'd250,  1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 16'h0100, 16'h0000, -32'sd100,     32'd0,         16'd150,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'h0000, 16'h0100, 16'h0000, 32'd100,       32'd0,         16'd100,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'h0000, 16'h0000, 16'h0100, 32'd100,       32'd0,         16'd0,    1'b0, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 16'h0000, 16'h0100, 32'd150,       32'd0,         16'd50,   1'b0, 1'b0};
    vecs[17] = '{1'b0, 16'h0000, 16'h0000, 16'h0100, 32'd120,       32'd0,         16'd30,   1'b1, 1'b0};

    // Reset held with enable high: nothing may move.
    rstn    = 1'b0;
    enable  = 1'b1;
    kp      = 16'h0100;
    ki      = 16'h0000;
    kd      = 16'h0000;
    desired = 32'd500;
    actual  = 32'd200;
    bad     = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (duty != 0 || dir || update || busy || sat) bad++;
    end
    checkOutput("outputs_in_reset_nonzero_cycles", bad, 0);

    // First update 16 edges after release, busy for 7 cycles, then every SAMPLE_DIV.
    rstn     = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
      if (update) break;
    end
    checkOutput("first_update_latency", edges, 16);
    checkOutput("busy_cycles", busy_cnt, 7);
    checkOutput("first_duty", duty, 300);
    waitUpdate(edges);
    checkOutput("update_interval", edges, SAMPLE_DIV);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      waitUpdate(edges);
      checkOutput($sformatf("vec%0d_latency", i), edges, vecs[i].restart ? 16 : SAMPLE_DIV);
      checkOutput($sformatf("vec%0d_duty", i), duty, vecs[i].exp_duty);
      checkOutput($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
      checkOutput($sformatf("vec%0d_sat", i), sat, vecs[i].exp_sat);
    end

    // Abort at T+4: outputs clear at T+5 and no update follows.
    waitBusyRise(ok);
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_duty", duty, 0);
    checkOutput("abort_dir", dir, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_update", update, 0);
    upd_cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (update) upd_cnt++;
    end
    checkOutput("abort_no_update_pulses", upd_cnt, 0);

    // Inputs changed after capture must not affect the sample in flight.
    kp      = 16'h0100;
    ki      = 16'h0000;
    kd      = 16'h0000;
    desired = 32'd500;
    actual  = 32'd200;
    enable  = 1'b1;
    waitBusyRise(ok);
    @(posedge clk);
    #1;
    desired = 32'd9000;
    waitUpdate(edges);
    checkOutput("stable_duty", duty, 300);
    checkOutput("stable_sat", sat, 0);
    waitUpdate(edges);
    checkOutput("next_sample_duty", duty, 1000);
    checkOutput("next_sample_sat", sat, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
